// File: rtl/multi_led_blink_pkg.sv
// rtl/multi_led_blink_pkg.sv - shared mode encoding for the multi-channel LED blinker
package multi_led_blink_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    // A half-period of zero behaves as one cycle
    function automatic logic [31:0] eff_half(input logic [31:0] h);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/multi_led_blink_channel.sv
// rtl/multi_led_blink_channel.sv - one LED channel: mode, half-period, counter and LED state
module blink_channel
    import multi_led_blink_pkg::*;
#(
    parameter int    DIV_W        = 27,
    parameter int    DEFAULT_HALF = 50_000_000,
    parameter mode_e RESET_MODE   = MODE_BLINK
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             we,
    input  logic [1:0]       wmode,
    input  logic [DIV_W-1:0] whalf,
    output logic             led,
    output logic             tick
);

    mode_e            mode;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // Terminal count is Heff-1; H=0 is treated as H=1 so the terminal count is 0
    always_comb begin
        last = (half == '0) ? '0 : half - DIV_W'(1);
    end

    // Channel state: writes win over counting, counting only while run is high
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            mode <= RESET_MODE;
            half <= DIV_W'(DEFAULT_HALF);
            cnt  <= '0;
            led  <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (we) begin
                mode <= mode_e'(wmode);
                half <= whalf;
                cnt  <= '0;
                led  <= (mode_e'(wmode) != MODE_OFF);
            end else if (run) begin
                case (mode)
                    MODE_OFF: begin
                        cnt <= '0;
                        led <= 1'b0;
                    end
                    MODE_ON: begin
                        cnt <= '0;
                        led <= 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt == last) begin
                            cnt  <= '0;
                            led  <= ~led;
                            tick <= 1'b1;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt == last) begin
                            cnt  <= '0;
                            led  <= 1'b0;
                            mode <= MODE_OFF;
                            tick <= 1'b1;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_led_blink.sv
// rtl/multi_led_blink.sv - N_CH independent LED channels with a shared config write port
module multi_led_blink
    import multi_led_blink_pkg::*;
#(
    parameter int    N_CH         = 4,
    parameter int    DIV_W        = 27,
    parameter int    DEFAULT_HALF = 50_000_000,
    parameter mode_e RESET_MODE   = MODE_BLINK
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_half,
    output logic [N_CH-1:0]  led,
    output logic [N_CH-1:0]  tick,
    output logic             cfg_err
);

    logic bad_ch;

    // Channel index outside the populated range
    always_comb begin
        bad_ch = (32'(cfg_ch) >= N_CH);
    end

    // Error pulse for writes that address a missing channel
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && bad_ch;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        blink_channel #(
            .DIV_W        (DIV_W),
            .DEFAULT_HALF (DEFAULT_HALF),
            .RESET_MODE   (RESET_MODE)
        ) u_ch (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .run    (run),
            .we     (cfg_we && (cfg_ch == 4'(g))),
            .wmode  (cfg_mode),
            .whalf  (cfg_half),
            .led    (led[g]),
            .tick   (tick[g])
        );
    end

endmodule
